block_spawn_ctrl: RTL and testbench

- Schedules falling-block objects into a fixed pool of NUM_SLOTS block renderers/movers.
- Spawns a new block every SPAWN_INTERVAL cycles into the lowest free slot, and frees slots when the owning block reports done.
- Supports pause, an optional total-block limit and a finished indication.
- Sits between the game top-level (Run/Pause) and the per-block datapath instances, which consume block_active[i] and spawn_valid/spawn_slot.

---
 rtl/game_pkg.sv | 14 +
 rtl/prio_enc_lowest.sv | 25 ++
 rtl/block_spawn_ctrl.sv | 162 ++++++++++++++++
 tb/tb_block_spawn_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level definitions: spawn controller FSM encoding and system clock rate.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        PAUSED   = 3'd2,
        DRAIN    = 3'd3,
        FINISHED = 3'd4
    } spawn_state_t;

    localparam int CLK_HZ = 50000000;

endpackage : game_pkg

// File: rtl/prio_enc_lowest.sv
// Lowest-set-bit priority encoder: reports whether any request bit is set and
// the index of the lowest one (index is 0 when nothing is set).
module prio_enc_lowest #(
    parameter int W     = 5,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     i_mask,
    output logic             o_found,
    output logic [IDX_W-1:0] o_index
);

    // Scan from the top down so the last match written is the lowest index.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; a path that leaves it unassigned infers a latch.
        o_found = |i_mask;
        o_index = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

endmodule : prio_enc_lowest

// File: rtl/block_spawn_ctrl.sv
// Falling-block spawn scheduler: issues one block every SPAWN_INTERVAL running
// cycles into the lowest free renderer slot, remembers one blocked spawn while
// the pool is full, and drains then finishes once the per-run limit is reached.
module block_spawn_ctrl
    import game_pkg::*;
#(
    parameter int NUM_SLOTS      = 5,
    parameter int SPAWN_INTERVAL = 50000000,
    parameter int MAX_BLOCKS     = 20,
    parameter int CNT_W          = 28
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Run,
    input  logic                         Pause,
    input  logic [NUM_SLOTS-1:0]         block_done,
    output logic [NUM_SLOTS-1:0]         block_active,
    output logic                         spawn_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
    output logic [7:0]                   spawn_count,
    output logic                         busy,
    output logic                         finished
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);

    spawn_state_t          r_state;
    logic                  r_run_prev;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pending;
    logic [7:0]            r_count;
    logic [NUM_SLOTS-1:0]  r_active;
    logic                  r_spawn_valid;
    logic [SLOT_W-1:0]     r_spawn_slot;

    spawn_state_t          w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_pending_nxt;
    logic [7:0]            w_count_nxt;
    logic [7:0]            w_count_inc;
    logic                  w_run_rise;
    logic                  w_attempt;
    logic                  w_spawn;
    logic [NUM_SLOTS-1:0]  w_free;
    logic [NUM_SLOTS-1:0]  w_done_eff;
    logic [NUM_SLOTS-1:0]  w_spawn_mask;
    logic [NUM_SLOTS-1:0]  w_active_nxt;
    logic                  w_found;
    logic [SLOT_W-1:0]     w_idx;

    // A slot finishing this cycle is already free, so it can be reused with no gap.
    assign w_free      = ~r_active | block_done;
    // Completions reported for idle slots carry no meaning and are dropped.
    assign w_done_eff  = block_done & r_active;
    assign w_run_rise  = Run & ~r_run_prev;
    assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

    prio_enc_lowest #(
        .W     (NUM_SLOTS),
        .IDX_W (SLOT_W)
    ) u_free_enc (
        .i_mask  (w_free),
        .o_found (w_found),
        .o_index (w_idx)
    );

    // Next-state, interval counter, pending flag and spawn decision.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        w_count_nxt   = r_count;
        w_attempt     = 1'b0;
        w_spawn       = 1'b0;
        case (r_state)
            IDLE, FINISHED: begin
                if (w_run_rise) begin
                    w_state_nxt   = RUN;
                    w_cnt_nxt     = '0;
                    w_count_nxt   = '0;
                    w_pending_nxt = 1'b0;
                end
            end
            RUN: begin
                // Pause wins over a coinciding attempt: counter frozen, nothing issued.
                if (Pause) begin
                    w_state_nxt = PAUSED;
                end else begin
                    w_attempt = (r_cnt == CNT_LAST);
                    w_cnt_nxt = w_attempt ? '0 : r_cnt + CNT_W'(1);
                    // A pending spawn and a fresh attempt collapse into one spawn.
                    if (w_attempt || r_pending) begin
                        if (w_found) begin
                            w_spawn       = 1'b1;
                            w_pending_nxt = 1'b0;
                            w_count_nxt   = w_count_inc;
                            if ((MAX_BLOCKS != 0) && (32'(w_count_inc) == MAX_BLOCKS)) begin
                                w_state_nxt = DRAIN;
                            end
                        end else begin
                            w_pending_nxt = 1'b1;
                        end
                    end
                end
            end
            PAUSED: begin
                if (!Pause) begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                w_pending_nxt = 1'b0;
                if (r_active == '0) begin
                    w_state_nxt = FINISHED;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Slot ownership: release on completion, claim on spawn (claim wins on the same slot).
    always_comb begin
        w_spawn_mask = w_spawn ? (NUM_SLOTS'(1) << w_idx) : '0;
        w_active_nxt = (r_active & ~w_done_eff) | w_spawn_mask;
    end

    // State and output registers, cleared asynchronously by Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (Reset) begin
            r_state       <= IDLE;
            r_run_prev    <= 1'b0;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_count       <= '0;
            r_active      <= '0;
            r_spawn_valid <= 1'b0;
            r_spawn_slot  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_run_prev    <= Run;
            r_cnt         <= w_cnt_nxt;
            r_pending     <= w_pending_nxt;
            r_count       <= w_count_nxt;
            r_active      <= w_active_nxt;
            r_spawn_valid <= w_spawn;
            r_spawn_slot  <= w_spawn ? w_idx : '0;
        end
    end

    assign block_active = r_active;
    assign spawn_valid  = r_spawn_valid;
    assign spawn_slot   = r_spawn_slot;
    assign spawn_count  = r_count;
    assign busy         = (r_state == RUN) || (r_state == PAUSED);
    assign finished     = (r_state == FINISHED);

endmodule : block_spawn_ctrl

// File: tb/tb_block_spawn_ctrl.sv
// Bench for block_spawn_ctrl with NUM_SLOTS=2, SPAWN_INTERVAL=4, MAX_BLOCKS=3.
// Expected spawns are queued by each scenario; a negedge monitor pops and compares.
module tb_block_spawn_ctrl;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       Pause;
    logic [1:0] block_done;
    logic [1:0] block_active;
    logic       spawn_valid;
    logic [0:0] spawn_slot;
    logic [7:0] spawn_count;
    logic       busy;
    logic       finished;

    typedef struct {
        int cyc;
        int slot;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    block_spawn_ctrl #(
        .NUM_SLOTS      (2),
        .SPAWN_INTERVAL (4),
        .MAX_BLOCKS     (3),
        .CNT_W          (3)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .Pause        (Pause),
        .block_done   (block_done),
        .block_active (block_active),
        .spawn_valid  (spawn_valid),
        .spawn_slot   (spawn_slot),
        .spawn_count  (spawn_count),
        .busy         (busy),
        .finished     (finished)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Edge counter used as the time base for expected spawn cycles.
    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard monitor: every spawn pulse must match the queue head.
    always @(negedge Clk) begin
        if (!Reset && spawn_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_spawn: cyc=%0d slot=%0d, required no spawn", cyc, spawn_slot);
            end else begin
                m_e = sb.pop_front();
                n_cmp++;
                if (cyc !== m_e.cyc) begin
                    n_bad++;
                    $display("FAIL spawn_cycle: got %0d, required %0d", cyc, m_e.cyc);
                end
                n_cmp++;
                if (int'(spawn_slot) !== m_e.slot) begin
                    n_bad++;
                    $display("FAIL spawn_slot: got %0d, required %0d", spawn_slot, m_e.slot);
                end
                n_cmp++;
                if (int'(spawn_count) !== m_e.cnt) begin
                    n_bad++;
                    $display("FAIL spawn_count_at_spawn: got %0d, required %0d", spawn_count, m_e.cnt);
                end
            end
        end
    end

    // Advance to 1 time unit after edge number c.
    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b1; Run = 1'b0; Pause = 1'b0; block_done = 2'b00;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    // Raise Run so the next edge sees a rising edge; returns that edge's number.
    task automatic start_run(output int c0);
        Run = 1'b1;
        @(posedge Clk);
        #1;
        c0  = cyc;
        Run = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b0; Pause = 1'b0; block_done = 2'b00;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        at_cycle(cyc + 6);
        n_cmp++;
        if ({block_active, spawn_valid, spawn_slot, spawn_count, busy, finished} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: act=%b sv=%b ss=%b cnt=%0d busy=%b fin=%b, required all 0",
                     block_active, spawn_valid, spawn_slot, spawn_count, busy, finished);
        end
    endtask

    // Cadence, full-pool pending spawn, drain, finish and restart.
    task automatic test_cadence_drain();
        int c0;
        int c1;
        int waited;
        apply_reset();
        start_run(c0);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL run_busy: got %b, required 1", busy); end
        sb.push_back('{c0 + 4, 0, 1});
        sb.push_back('{c0 + 8, 1, 2});
        at_cycle(c0 + 9);
        n_cmp++;
        if (block_active !== 2'b11) begin n_bad++; $display("FAIL cadence_active: got %b, required 11", block_active); end
        // Attempt at edge c0+12 finds the pool full: pending, no pulse.
        at_cycle(c0 + 13);
        n_cmp++;
        if (spawn_count !== 8'd2) begin n_bad++; $display("FAIL pending_count: got %0d, required 2", spawn_count); end
        block_done = 2'b01;
        sb.push_back('{c0 + 14, 0, 3});
        at_cycle(c0 + 14);
        block_done = 2'b00;
        n_cmp++;
        if (block_active !== 2'b11) begin n_bad++; $display("FAIL pending_active: got %b, required 11", block_active); end
        n_cmp++;
        if ({busy, finished} !== 2'b00) begin n_bad++; $display("FAIL drain_state: busy/fin=%b, required 00", {busy, finished}); end
        block_done = 2'b10;
        at_cycle(c0 + 15);
        block_done = 2'b00;
        n_cmp++;
        if (block_active !== 2'b01) begin n_bad++; $display("FAIL drain_free1: got %b, required 01", block_active); end
        block_done = 2'b01;
        at_cycle(c0 + 16);
        block_done = 2'b00;
        waited = 0;
        while (!finished && waited < 6) begin
            at_cycle(cyc + 1);
            waited++;
        end
        n_cmp++;
        if ({finished, block_active} !== 3'b100) begin
            n_bad++;
            $display("FAIL finished: fin=%b act=%b, required fin=1 act=00", finished, block_active);
        end
        n_cmp++;
        if (spawn_count !== 8'd3) begin n_bad++; $display("FAIL finished_count: got %0d, required 3", spawn_count); end
        start_run(c1);
        n_cmp++;
        if ({busy, finished, spawn_count} !== {2'b10, 8'd0}) begin
            n_bad++;
            $display("FAIL restart: busy=%b fin=%b cnt=%0d, required 1 0 0", busy, finished, spawn_count);
        end
        sb.push_back('{c1 + 4, 0, 1});
        at_cycle(c1 + 5);
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL cadence_sb: %0d spawns missing, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_pause();
        int c0;
        apply_reset();
        start_run(c0);
        // Pause seen at edges c0+2..c0+9; counter is also held on the edge leaving PAUSED,
        // so 9 edges are frozen and the first attempt moves from c0+4 to c0+13.
        at_cycle(c0 + 1);
        Pause = 1'b1;
        at_cycle(c0 + 9);
        Pause = 1'b0;
        sb.push_back('{c0 + 13, 0, 1});
        at_cycle(c0 + 13);
        n_cmp++;
        if (block_active !== 2'b01) begin n_bad++; $display("FAIL pause_spawn_active: got %b, required 01", block_active); end
        Pause = 1'b1;
        at_cycle(c0 + 15);
        block_done = 2'b01;
        at_cycle(c0 + 16);
        block_done = 2'b00;
        n_cmp++;
        if ({busy, block_active} !== 3'b100) begin
            n_bad++;
            $display("FAIL paused_done: busy=%b act=%b, required busy=1 act=00", busy, block_active);
        end
        at_cycle(c0 + 22);
        Pause = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL pause_sb: %0d spawns missing, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_same_cycle_reuse();
        int c0;
        apply_reset();
        start_run(c0);
        sb.push_back('{c0 + 4, 0, 1});
        sb.push_back('{c0 + 8, 1, 2});
        at_cycle(c0 + 11);
        block_done = 2'b10;
        sb.push_back('{c0 + 12, 1, 3});
        at_cycle(c0 + 12);
        block_done = 2'b00;
        n_cmp++;
        if (block_active !== 2'b11) begin n_bad++; $display("FAIL reuse_active: got %b, required 11", block_active); end
        at_cycle(c0 + 13);
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL reuse_sb: %0d spawns missing, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_async_reset();
        int c0;
        apply_reset();
        start_run(c0);
        sb.push_back('{c0 + 4, 0, 1});
        sb.push_back('{c0 + 8, 1, 2});
        at_cycle(c0 + 9);
        #2 Reset = 1'b1;
        #1;
        n_cmp++;
        if ({block_active, spawn_valid, spawn_slot, spawn_count, busy, finished} !== 14'd0) begin
            n_bad++;
            $display("FAIL async_reset: act=%b sv=%b cnt=%0d busy=%b fin=%b, required all 0",
                     block_active, spawn_valid, spawn_count, busy, finished);
        end
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        at_cycle(cyc + 10);
        n_cmp++;
        if ({busy, block_active, spawn_count} !== 11'd0) begin
            n_bad++;
            $display("FAIL post_reset_idle: busy=%b act=%b cnt=%0d, required 0", busy, block_active, spawn_count);
        end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL async_sb: %0d spawns missing, required 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_cadence_drain();
        test_pause();
        test_same_cycle_reuse();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_block_spawn_ctrl
